sa_gemm_ctrl: RTL and testbench

//  Sequencer for one weight-stationary GEMM tile on the systolic array datapath. On i_start it reads the

---
 rtl/sa_gemm_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_sa_gemm_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_gemm_ctrl.sv
// sa_gemm_ctrl: sequencer for one weight-stationary GEMM tile.
// Flow: load the weight tile from the top SRAM, stream activations from the left SRAM,
// then collect datapath output rows into the down SRAM.
// Optional feature macro: SA_CTRL_PERF_CNT_EN adds o_cycle_cnt, a saturating count of busy cycles.
module sa_gemm_ctrl #(
    parameter int NUM_ROW              = 8,
    parameter int NUM_COL              = 8,
    parameter int LOG2_SRAM_BANK_DEPTH = 10,
    parameter int DRAIN_TIMEOUT        = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_sram_rd_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_sram_rd_end_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_sram_rd_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_sram_rd_end_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_sram_wr_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_sram_wr_end_addr,
    input  logic [NUM_COL-1:0]              i_sa_valid,
    output logic                            o_top_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_addr,
    output logic                            o_left_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_addr,
    output logic [NUM_COL-1:0]              o_top_valid,
    output logic [NUM_ROW-1:0]              o_left_valid,
    output logic                            o_down_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_wr_addr,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err
`ifdef SA_CTRL_PERF_CNT_EN
   ,output logic [31:0]                     o_cycle_cnt
`endif
);

    localparam int AW  = LOG2_SRAM_BANK_DEPTH;
    localparam int WDW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_TOP  = 2'd1,
        S_FEED_LEFT = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   top_addr_q, top_addr_d;
    logic [AW-1:0]   top_end_q, top_end_d;
    logic [AW-1:0]   left_addr_q, left_addr_d;
    logic [AW-1:0]   left_end_q, left_end_d;
    logic [AW-1:0]   down_addr_q, down_addr_d;
    logic [AW-1:0]   down_end_q, down_end_d;
    logic [WDW-1:0]  wd_cnt_q, wd_cnt_d;
    logic            wr_done_q, wr_done_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            top_vld_q, top_vld_d;
    logic            left_vld_q, left_vld_d;
    logic            top_rd_en_s;
    logic            left_rd_en_s;
    logic            wr_en_s;
    logic            bad_range_s;

    // Read strobes decode straight from the state register; a write needs an output row,
    // a state that accepts results, and room left in the down address range.
    assign top_rd_en_s  = (state_q == S_LOAD_TOP);
    assign left_rd_en_s = (state_q == S_FEED_LEFT);
    assign wr_en_s      = ((state_q == S_FEED_LEFT) || (state_q == S_DRAIN))
                          && (|i_sa_valid) && !wr_done_q;
    assign bad_range_s  = (i_top_sram_rd_end_addr  < i_top_sram_rd_start_addr)
                       || (i_left_sram_rd_end_addr < i_left_sram_rd_start_addr)
                       || (i_down_sram_wr_end_addr < i_down_sram_wr_start_addr);

    assign o_top_rd_en    = top_rd_en_s;
    assign o_top_rd_addr  = top_addr_q;
    assign o_left_rd_en   = left_rd_en_s;
    assign o_left_rd_addr = left_addr_q;
    assign o_top_valid    = {NUM_COL{top_vld_q}};
    assign o_left_valid   = {NUM_ROW{left_vld_q}};
    assign o_down_wr_en   = wr_en_s;
    assign o_down_wr_addr = down_addr_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = done_q;
    assign o_err          = err_q;

    // Next-state logic for the phase sequencer, address counters, watchdog and flags.
    always_comb begin
        state_d     = state_q;
        top_addr_d  = top_addr_q;
        top_end_d   = top_end_q;
        left_addr_d = left_addr_q;
        left_end_d  = left_end_q;
        down_addr_d = down_addr_q;
        down_end_d  = down_end_q;
        wd_cnt_d    = wd_cnt_q;
        wr_done_d   = wr_done_q;
        err_d       = err_q;
        done_d      = 1'b0;
        top_vld_d   = top_rd_en_s;
        left_vld_d  = left_rd_en_s;

        // The write counter parks on the end address once the last row has landed.
        if (wr_en_s) begin
            if (down_addr_q == down_end_q) begin
                wr_done_d = 1'b1;
            end else begin
                down_addr_d = down_addr_q + AW'(1);
            end
        end else begin
            wr_done_d = wr_done_d;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    top_addr_d  = i_top_sram_rd_start_addr;
                    top_end_d   = i_top_sram_rd_end_addr;
                    left_addr_d = i_left_sram_rd_start_addr;
                    left_end_d  = i_left_sram_rd_end_addr;
                    down_addr_d = i_down_sram_wr_start_addr;
                    down_end_d  = i_down_sram_wr_end_addr;
                    wd_cnt_d    = {WDW{1'b0}};
                    wr_done_d   = 1'b0;
                    err_d       = 1'b0;
                    if (bad_range_s) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD_TOP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_TOP: begin
                if (top_addr_q == top_end_q) begin
                    state_d = S_FEED_LEFT;
                end else begin
                    top_addr_d = top_addr_q + AW'(1);
                end
            end
            S_FEED_LEFT: begin
                wd_cnt_d = {WDW{1'b0}};
                if (left_addr_q == left_end_q) begin
                    state_d = S_DRAIN;
                end else begin
                    left_addr_d = left_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // If every row already landed during FEED_LEFT, one DRAIN cycle closes the tile.
                if (wr_done_q || (wr_en_s && (down_addr_q == down_end_q))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (wr_en_s) begin
                    wd_cnt_d = {WDW{1'b0}};
                end else if (wd_cnt_q == WDW'(DRAIN_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath-control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            top_addr_q  <= {AW{1'b0}};
            top_end_q   <= {AW{1'b0}};
            left_addr_q <= {AW{1'b0}};
            left_end_q  <= {AW{1'b0}};
            down_addr_q <= {AW{1'b0}};
            down_end_q  <= {AW{1'b0}};
            wd_cnt_q    <= {WDW{1'b0}};
            wr_done_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            top_vld_q   <= 1'b0;
            left_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            top_addr_q  <= top_addr_d;
            top_end_q   <= top_end_d;
            left_addr_q <= left_addr_d;
            left_end_q  <= left_end_d;
            down_addr_q <= down_addr_d;
            down_end_q  <= down_end_d;
            wd_cnt_q    <= wd_cnt_d;
            wr_done_q   <= wr_done_d;
            done_q      <= done_d;
            err_q       <= err_d;
            top_vld_q   <= top_vld_d;
            left_vld_q  <= left_vld_d;
        end
    end

`ifdef SA_CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    assign o_cycle_cnt = cyc_cnt_q;

    // Busy-cycle counter: cleared by an accepted start, saturates, holds while idle.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if ((state_q == S_IDLE) && i_start) begin
            cyc_cnt_d = 32'd0;
        end else if ((state_q != S_IDLE) && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end else begin
            cyc_cnt_d = cyc_cnt_q;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt_q <= 32'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_sa_gemm_ctrl.sv
// Self-checking bench for sa_gemm_ctrl: directed vector table, reset-abort sequence,
// and randomized tiles checked against a cycle-schedule model built from the phase rules.
module tb_sa_gemm_ctrl;

    localparam int NR = 8;
    localparam int NC = 8;
    localparam int AW = 10;
    localparam int TO = 16;
    localparam int MAXC = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] ts_i = '0, te_i = '0, ls_i = '0, le_i = '0, ds_i = '0, de_i = '0;
    logic [NC-1:0] sa_valid = '0;
    logic          top_en, left_en, wr_en, busy, done, err;
    logic [AW-1:0] top_addr, left_addr, wr_addr;
    logic [NC-1:0] top_vld;
    logic [NR-1:0] left_vld;
`ifdef SA_CTRL_PERF_CNT_EN
    logic [31:0]   cyc_cnt;
`endif

    int total = 0;
    int bad = 0;

    sa_gemm_ctrl #(
        .NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW), .DRAIN_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_top_sram_rd_start_addr(ts_i), .i_top_sram_rd_end_addr(te_i),
        .i_left_sram_rd_start_addr(ls_i), .i_left_sram_rd_end_addr(le_i),
        .i_down_sram_wr_start_addr(ds_i), .i_down_sram_wr_end_addr(de_i),
        .i_sa_valid(sa_valid),
        .o_top_rd_en(top_en), .o_top_rd_addr(top_addr),
        .o_left_rd_en(left_en), .o_left_rd_addr(left_addr),
        .o_top_valid(top_vld), .o_left_valid(left_vld),
        .o_down_wr_en(wr_en), .o_down_wr_addr(wr_addr),
        .o_busy(busy), .o_done(done), .o_err(err)
`ifdef SA_CTRL_PERF_CNT_EN
       ,.o_cycle_cnt(cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int ts, te, ls, le, ds, de;
        int dens;       // percent chance of an output row per cycle
        int restart;    // cycle index of an ignored i_start, 0 = none
        bit directed;   // exp_done/exp_err are hand-computed
        int exp_done;
        bit exp_err;
    } vec_t;

    // Expected per-cycle schedule (cycle 0 = start cycle).
    bit exp_te[0:MAXC-1];
    int exp_ta[0:MAXC-1];
    bit exp_le[0:MAXC-1];
    int exp_la[0:MAXC-1];
    bit exp_we[0:MAXC-1];
    int exp_wa[0:MAXC-1];
    bit vpat[0:MAXC-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " top_en"}, 32'(top_en), 32'd0);
        check({tag, " left_en"}, 32'(left_en), 32'd0);
        check({tag, " wr_en"}, 32'(wr_en), 32'd0);
        check({tag, " top_addr"}, 32'(top_addr), 32'd0);
        check({tag, " left_addr"}, 32'(left_addr), 32'd0);
        check({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, " top_vld"}, 32'(top_vld), 32'd0);
        check({tag, " left_vld"}, 32'(left_vld), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    // Build the expected schedule from the tile rules, then drive and check every cycle.
    task automatic run_txn(input vec_t t, input string tag);
        int nt, nl, nd, w, gap, c, last, done_cyc;
        bit badr, merr, fin;
        logic [NC-1:0] v;
        for (int i = 0; i < MAXC; i++) begin
            exp_te[i] = 1'b0; exp_le[i] = 1'b0; exp_we[i] = 1'b0;
            exp_ta[i] = 0; exp_la[i] = 0; exp_wa[i] = 0;
            vpat[i] = ($urandom_range(0, 99) < t.dens);
        end
        badr = (t.te < t.ts) || (t.le < t.ls) || (t.de < t.ds);
        merr = badr;
        last = 0;
        if (!badr) begin
            nt = t.te - t.ts + 1;
            nl = t.le - t.ls + 1;
            nd = t.de - t.ds + 1;
            for (int i = 1; i <= nt; i++) begin
                exp_te[i] = 1'b1; exp_ta[i] = t.ts + i - 1;
            end
            for (int i = 1; i <= nl; i++) begin
                exp_le[nt + i] = 1'b1; exp_la[nt + i] = t.ls + i - 1;
            end
            w = 0; gap = 0; c = nt + 1; fin = 1'b0;
            while (!fin && c < MAXC - 2) begin
                if (c <= nt + nl) begin
                    if (vpat[c] && w < nd) begin
                        exp_we[c] = 1'b1; exp_wa[c] = t.ds + w; w++;
                    end
                end else if (w == nd) begin
                    last = c; fin = 1'b1;
                end else if (vpat[c]) begin
                    exp_we[c] = 1'b1; exp_wa[c] = t.ds + w; w++; gap = 0;
                    if (w == nd) begin last = c; fin = 1'b1; end
                end else begin
                    gap++;
                    if (gap == TO) begin last = c; fin = 1'b1; merr = 1'b1; end
                end
                c++;
            end
        end
        done_cyc = last + 1;
        if (t.directed) begin
            check({tag, " model done cycle"}, 32'(done_cyc), 32'(t.exp_done));
            check({tag, " model err"}, 32'(merr), 32'(t.exp_err));
        end

        for (int cy = 0; cy <= done_cyc + 1; cy++) begin
            @(negedge clk);
            if (cy == 0) begin
                i_start = 1'b1;
                ts_i = AW'(t.ts); te_i = AW'(t.te); ls_i = AW'(t.ls);
                le_i = AW'(t.le); ds_i = AW'(t.ds); de_i = AW'(t.de);
                sa_valid = '0;
            end else begin
                i_start = (cy == t.restart);
                ts_i = AW'($urandom); te_i = AW'($urandom); ls_i = AW'($urandom);
                le_i = AW'($urandom); ds_i = AW'($urandom); de_i = AW'($urandom);
                v = NC'($urandom_range(1, 255));
                sa_valid = vpat[cy] ? v : '0;
            end
            #1;
            if (cy >= 1) begin
                check({tag, " busy"}, 32'(busy), 32'(cy <= last));
                check({tag, " top_en"}, 32'(top_en), 32'(exp_te[cy]));
                if (exp_te[cy]) check({tag, " top_addr"}, 32'(top_addr), 32'(exp_ta[cy]));
                check({tag, " left_en"}, 32'(left_en), 32'(exp_le[cy]));
                if (exp_le[cy]) check({tag, " left_addr"}, 32'(left_addr), 32'(exp_la[cy]));
                check({tag, " top_vld"}, 32'(top_vld), exp_te[cy-1] ? 32'hFF : 32'h0);
                check({tag, " left_vld"}, 32'(left_vld), exp_le[cy-1] ? 32'hFF : 32'h0);
                check({tag, " wr_en"}, 32'(wr_en), 32'(exp_we[cy]));
                if (exp_we[cy]) check({tag, " wr_addr"}, 32'(wr_addr), 32'(exp_wa[cy]));
                check({tag, " done"}, 32'(done), 32'(cy == done_cyc));
                check({tag, " err"}, 32'(err), (cy >= done_cyc) ? 32'(merr) : 32'd0);
`ifdef SA_CTRL_PERF_CNT_EN
                if (cy == 1) check({tag, " cnt cleared"}, cyc_cnt, 32'd0);
                if (cy >= done_cyc) check({tag, " cnt busy cycles"}, cyc_cnt, 32'(last));
`endif
            end
        end
        @(negedge clk);
        i_start = 1'b0;
        sa_valid = '0;
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        //                ts te ls le ds de dens rst dir done err
        vecs[0] = '{0, 3, 0, 3, 0, 3, 100, 0, 1'b1, 10, 1'b0};   // 4x4 tile
        vecs[1] = '{5, 2, 0, 3, 0, 3, 100, 0, 1'b1, 1, 1'b1};    // top end < start
        vecs[2] = '{0, 3, 10, 15, 20, 23, 100, 7, 1'b1, 12, 1'b0}; // start while busy
        vecs[3] = '{0, 3, 0, 3, 0, 3, 0, 0, 1'b1, 25, 1'b1};     // drain watchdog
        vecs[4] = '{7, 7, 9, 9, 3, 3, 100, 0, 1'b1, 4, 1'b0};    // single-entry phases
        vecs[5] = '{0, 1, 0, 1, 5, 4, 100, 0, 1'b1, 1, 1'b1};    // down end < start
        vecs[6] = '{0, 1, 0, 0, 0, 5, 100, 0, 1'b1, 9, 1'b0};    // writes finish in DRAIN

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of LOAD_TOP at address 2, then a clean tile.
        @(negedge clk);
        i_start = 1'b1;
        ts_i = 10'd0; te_i = 10'd3; ls_i = 10'd0; le_i = 10'd3; ds_i = 10'd0; de_i = 10'd3;
        for (int cy = 1; cy <= 3; cy++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        #1;
        check("rst_mid top_addr", 32'(top_addr), 32'd2);
        check("rst_mid top_en", 32'(top_en), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("rst_mid after");
        rst_n = 1'b1;
        run_txn(vecs[0], "after_rst");

        for (int k = 0; k < 20; k++) begin
            rv.ts = $urandom_range(1, 1000); rv.te = rv.ts + $urandom_range(0, 7);
            rv.ls = $urandom_range(1, 1000); rv.le = rv.ls + $urandom_range(0, 7);
            rv.ds = $urandom_range(1, 1000); rv.de = rv.ds + $urandom_range(0, 7);
            if (k % 7 == 3) rv.le = rv.ls - 1;
            rv.dens = $urandom_range(30, 95);
            rv.restart = (k % 3 == 0 && k % 7 != 3) ? $urandom_range(1, rv.te - rv.ts + 1) : 0;
            rv.directed = 1'b0; rv.exp_done = 0; rv.exp_err = 1'b0;
            run_txn(rv, $sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
